// File: rtl/sonar_rx_serial_cmd.sv
// rtl/sonar_rx_serial_cmd.sv - 7O1 serial receiver and sonar command decoder (parity check under RX_PARITY_CHECK_EN)
module sonar_rx_serial_cmd #(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [6:0] CMD_MEDIR    = 7'h6D,
   parameter logic [6:0] CMD_PARAR    = 7'h70,
   parameter logic [6:0] CMD_RESET    = 7'h72
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [6:0] dado_recebido,
   output logic       pronto,
   output logic       erro,
   output logic       cmd_medir,
   output logic       cmd_parar,
   output logic       cmd_reset,
   output logic       medindo,
   output logic [3:0] db_estado
);

   localparam logic [3:0] INICIAL  = 4'd0;
   localparam logic [3:0] ESPERA   = 4'd1;
   localparam logic [3:0] INICIO   = 4'd2;
   localparam logic [3:0] DADOS    = 4'd3;
   localparam logic [3:0] PARIDADE = 4'd4;
   localparam logic [3:0] PARADA   = 4'd5;
   localparam logic [3:0] VERIFICA = 4'd6;
   localparam logic [3:0] FINAL    = 4'd7;

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CLK = CW'(CLKS_PER_BIT / 2 - 1);

   logic          rx_meta;
   logic          rx_sync;
   logic          armed;      // line seen high since the last start/stop sample
   logic [3:0]    estado;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_cnt;
   logic [6:0]    shreg;
   logic          stop_bit;
   logic          bit_tick;
   logic          frame_ok;

   assign bit_tick  = (clk_cnt == LAST_CLK);
   assign db_estado = estado;

`ifdef RX_PARITY_CHECK_EN
   logic par_bit;
   assign frame_ok = stop_bit && ((^shreg ^ par_bit) == 1'b1);
`else
   assign frame_ok = stop_bit;
`endif

   // two-flop synchronizer on the asynchronous rx pin, idles high
   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // receive FSM: start validation, mid-bit sampling, frame check and command decode
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado        <= INICIAL;
         clk_cnt       <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         stop_bit      <= 1'b0;
         armed         <= 1'b0;
         dado_recebido <= '0;
         erro          <= 1'b0;
         pronto        <= 1'b0;
         cmd_medir     <= 1'b0;
         cmd_parar     <= 1'b0;
         cmd_reset     <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
         par_bit       <= 1'b0;
`endif
      end else begin
         pronto    <= 1'b0;
         cmd_medir <= 1'b0;
         cmd_parar <= 1'b0;
         cmd_reset <= 1'b0;
         if (rx_sync) armed <= 1'b1;
         case (estado)
            INICIAL: estado <= ESPERA;
            ESPERA: begin
               // a low level only starts a frame after the line was high (edge, not break)
               if (!rx_sync && armed) begin
                  estado  <= INICIO;
                  clk_cnt <= '0;
                  armed   <= 1'b0;
               end
            end
            INICIO: begin
               if (clk_cnt == HALF_CLK) begin
                  clk_cnt <= '0;
                  bit_cnt <= '0;
                  estado  <= rx_sync ? ESPERA : DADOS;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DADOS: begin
               clk_cnt <= bit_tick ? '0 : clk_cnt + 1'b1;
               if (bit_tick) begin
                  shreg   <= {rx_sync, shreg[6:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd6) estado <= PARIDADE;
               end
            end
            PARIDADE: begin
               clk_cnt <= bit_tick ? '0 : clk_cnt + 1'b1;
               if (bit_tick) begin
`ifdef RX_PARITY_CHECK_EN
                  par_bit <= rx_sync;
`endif
                  estado  <= PARADA;
               end
            end
            PARADA: begin
               clk_cnt <= bit_tick ? '0 : clk_cnt + 1'b1;
               if (bit_tick) begin
                  stop_bit <= rx_sync;
                  if (!rx_sync) armed <= 1'b0;
                  estado   <= VERIFICA;
               end
            end
            VERIFICA: begin
               pronto <= 1'b1;
               if (frame_ok) begin
                  dado_recebido <= shreg;
                  erro          <= 1'b0;
                  cmd_medir     <= (shreg == CMD_MEDIR);
                  cmd_parar     <= (shreg == CMD_PARAR);
                  cmd_reset     <= (shreg == CMD_RESET);
               end else begin
                  erro <= 1'b1;
               end
               estado <= FINAL;
            end
            FINAL:   estado <= ESPERA;
            default: estado <= INICIAL;
         endcase
      end
   end

   // measurement level follows the decoded command pulses, reset/stop dominate
   always_ff @(posedge clock) begin
      if (!reset) begin
         medindo <= 1'b0;
      end else if (cmd_reset || cmd_parar) begin
         medindo <= 1'b0;
      end else if (cmd_medir) begin
         medindo <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sonar_rx_serial_cmd.sv
// tb/tb_sonar_rx_serial_cmd.sv - randomized self-checking bench for sonar_rx_serial_cmd
module tb_sonar_rx_serial_cmd;

   localparam int CPB = 16;
`ifdef RX_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       rx    = 1'b1;
   logic [6:0] dado_recebido;
   logic       pronto, erro, cmd_medir, cmd_parar, cmd_reset, medindo;
   logic [3:0] db_estado;

   always #5 clock = ~clock;

   sonar_rx_serial_cmd #(.CLKS_PER_BIT(CPB)) dut (
      .clock(clock), .reset(reset), .rx(rx),
      .dado_recebido(dado_recebido), .pronto(pronto), .erro(erro),
      .cmd_medir(cmd_medir), .cmd_parar(cmd_parar), .cmd_reset(cmd_reset),
      .medindo(medindo), .db_estado(db_estado)
   );

   typedef struct {
      logic [6:0] d;
      logic       p;
      logic       s;
   } frame_t;

   int         total = 0;
   int         bad   = 0;
   frame_t     exp_q[$];
   logic [6:0] m_dado;
   logic       m_erro, m_medindo;
   bit         pend, pend_val;
   logic       rst_seen;
   bit         started = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic odd_par(input logic [6:0] d);
      return ~^d;
   endfunction

   always @(posedge clock) rst_seen <= reset;

   // reference model: each pronto consumes one sent frame; levels checked every cycle
   always @(negedge clock) begin
      frame_t f;
      logic   ok, em, ep, er;
      if (rst_seen === 1'b0) begin
         started   = 1'b1;
         exp_q.delete();
         m_dado    = '0;
         m_erro    = 1'b0;
         m_medindo = 1'b0;
         pend      = 1'b0;
         check("rst_outs", {dado_recebido, pronto, erro, cmd_medir, cmd_parar, cmd_reset, medindo}, 0);
         check("rst_state", db_estado, 0);
      end else if (started) begin
         if (pend) begin
            m_medindo = pend_val;
            pend      = 1'b0;
         end
         if (pronto) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_pronto: got 1 expected 0 at %0t", $time);
            end else begin
               f  = exp_q.pop_front();
               ok = f.s && (!PAR_EN || (f.p == odd_par(f.d)));
               if (ok) m_dado = f.d;
               m_erro = !ok;
               em = ok && (f.d == 7'h6D);
               ep = ok && (f.d == 7'h70);
               er = ok && (f.d == 7'h72);
               if (er || ep) begin pend = 1'b1; pend_val = 1'b0; end
               else if (em)  begin pend = 1'b1; pend_val = 1'b1; end
               check("cmd_pulses", {cmd_medir, cmd_parar, cmd_reset}, {em, ep, er});
            end
         end else begin
            check("idle_cmds", {cmd_medir, cmd_parar, cmd_reset}, 0);
         end
         check("dado", dado_recebido, m_dado);
         check("erro", erro, m_erro);
         check("medindo", medindo, m_medindo);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input logic [6:0] d, input logic p, input logic s, input int gap);
      exp_q.push_back('{d, p, s});
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 7; i++) begin
         rx = d[i];
         tick(CPB);
      end
      rx = p;
      tick(CPB);
      rx = s;
      tick(CPB);
      rx = 1'b1;
      tick(gap);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         tick(1);
         n++;
      end
      check(name, exp_q.size(), 0);
      tick(4);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      logic [6:0] d;
      logic       p, s;
      int         g, sel;

      check("pin_par_m", odd_par(7'h6D), 0);
      check("pin_par_r", odd_par(7'h72), 1);

      reset = 1'b0;
      rx    = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(1);
      @(negedge clock);
      check("after_reset_state", db_estado, 1);

      send_frame(7'h6D, 1'b0, 1'b1, 3 * CPB);
      wait_drain("drain_m");
      check("m_dado", dado_recebido, 7'h6D);
      check("m_medindo", medindo, 1);
      check("m_erro", erro, 0);

      send_frame(7'h70, 1'b0, 1'b1, 0);
      send_frame(7'h72, 1'b1, 1'b1, 3 * CPB);
      wait_drain("drain_pr");
      check("pr_dado", dado_recebido, 7'h72);
      check("pr_medindo", medindo, 0);

      send_frame(7'h6D, 1'b1, 1'b1, 3 * CPB);
      wait_drain("drain_bad_par");
      check("par_erro", erro, PAR_EN ? 1 : 0);
      check("par_dado", dado_recebido, PAR_EN ? 7'h72 : 7'h6D);

      send_frame(7'h41, 1'b1, 1'b0, 3 * CPB);
      wait_drain("drain_bad_stop");
      check("stop_erro", erro, 1);
      send_frame(7'h41, 1'b1, 1'b1, 3 * CPB);
      wait_drain("drain_A");
      check("A_erro", erro, 0);
      check("A_dado", dado_recebido, 7'h41);

      exp_q.push_back('{7'h00, 1'b0, 1'b0});
      rx = 1'b0;
      tick(12 * CPB);
      check("break_state", db_estado, 1);
      rx = 1'b1;
      tick(3 * CPB);
      wait_drain("drain_break");
      check("break_erro", erro, 1);

      rx = 1'b0;
      tick(CPB / 4);
      rx = 1'b1;
      tick(2);
      check("glitch_inicio", db_estado, 2);
      tick(CPB);
      check("glitch_back", db_estado, 1);

      rx = 1'b0;
      tick(CPB);
      rx = 1'b1;
      tick(CPB);
      rx = 1'b0;
      tick(CPB / 2);
      check("mid_dados", db_estado, 3);
      reset = 1'b0;
      rx    = 1'b1;
      tick(2);
      reset = 1'b1;
      tick(1);
      check("mid_reset_state", db_estado, 1);
      check("mid_reset_dado", dado_recebido, 0);
      tick(3 * CPB);

      for (int k = 0; k < 30; k++) begin
         sel = $urandom_range(0, 3);
         d   = (sel == 0) ? 7'h6D : (sel == 1) ? 7'h70 : (sel == 2) ? 7'h72 : 7'($urandom);
         p   = odd_par(d);
         if ($urandom_range(0, 9) == 0) p = ~p;
         s   = ($urandom_range(0, 9) != 0);
         g   = $urandom_range(0, 12);
         if (!s && g < 4) g = 4;
         send_frame(d, p, s, g);
      end
      wait_drain("drain_random");
      tick(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
